// File: rtl/md_ring_pkg.sv
// Shared ring packet field widths, typedefs and coordinate-to-node mapping.
// The struct typedefs describe the default 4x4x4 build; modules slice flat vectors by their own parameters.
package md_ring_pkg;
  localparam int DEF_DATA_WIDTH        = 32;
  localparam int DEF_CELL_ID_WIDTH     = 3;
  localparam int DEF_PARTICLE_ID_WIDTH = 7;
  localparam int DEF_NODE_ID_WIDTH     = 6;
  localparam int ERR_CNT_WIDTH         = 16;

  typedef logic [ERR_CNT_WIDTH-1:0] err_cnt_t;

  typedef struct packed {
    logic [DEF_CELL_ID_WIDTH-1:0]     cell_x;
    logic [DEF_CELL_ID_WIDTH-1:0]     cell_y;
    logic [DEF_CELL_ID_WIDTH-1:0]     cell_z;
    logic [DEF_PARTICLE_ID_WIDTH-1:0] particle_id;
    logic [DEF_DATA_WIDTH-1:0]        fx;
    logic [DEF_DATA_WIDTH-1:0]        fy;
    logic [DEF_DATA_WIDTH-1:0]        fz;
  } wb_t;

  typedef struct packed {
    logic [DEF_NODE_ID_WIDTH-1:0]     dest_node;
    logic [DEF_PARTICLE_ID_WIDTH-1:0] particle_id;
    logic [DEF_DATA_WIDTH-1:0]        fx;
    logic [DEF_DATA_WIDTH-1:0]        fy;
    logic [DEF_DATA_WIDTH-1:0]        fz;
  } pkt_t;

  // 1-based coordinate with one halo cell each side; anything beyond is garbage
  function automatic logic axis_ok(input int v, input int n);
    return v <= n + 1;
  endfunction

  function automatic int axis_idx(input int v, input int n);
    if (v == 0) return n - 1;
    if (v == n + 1) return 0;
    return v - 1;
  endfunction

  function automatic int coord_to_node(input int x, input int y, input int z,
                                       input int xs, input int ys, input int zs);
    return axis_idx(z, zs) * xs * ys + axis_idx(y, ys) * xs + axis_idx(x, xs);
  endfunction
endpackage

// File: rtl/dest_id_map_chan.sv
// One channel: coordinate wrap/validate, node-id map and packet FIFO.
// Optional saturating drop counter built when DEST_MAP_ERR_CNT_EN is defined.
module dest_id_map_chan
  import md_ring_pkg::*;
#(
  parameter int NUM_CELLS         = 64,
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int XSIZE             = 4,
  parameter int YSIZE             = 4,
  parameter int ZSIZE             = 4,
  parameter int FIFO_DEPTH        = 4,
  parameter int NODE_ID_WIDTH     = $clog2(NUM_CELLS),
  parameter int WB_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH + 3*DATA_WIDTH,
  parameter int PACKET_WIDTH      = NODE_ID_WIDTH + PARTICLE_ID_WIDTH + 3*DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_valid,
  input  logic [WB_WIDTH-1:0]     wb_in,
  output logic                    wb_ready,
  output logic                    pkt_valid,
  output logic [PACKET_WIDTH-1:0] pkt_out,
  input  logic                    pkt_ready
`ifdef DEST_MAP_ERR_CNT_EN
  ,
  output err_cnt_t                err_cnt
`endif
);
  localparam int PAYLOAD_WIDTH = PARTICLE_ID_WIDTH + 3*DATA_WIDTH;
  localparam int PTR_W         = $clog2(FIFO_DEPTH);
  localparam int CNT_W         = PTR_W + 1;

  logic [CELL_ID_WIDTH-1:0]  w_cx, w_cy, w_cz;
  logic [PAYLOAD_WIDTH-1:0]  w_payload;
  logic [NODE_ID_WIDTH-1:0]  w_dest;
  logic [PACKET_WIDTH-1:0]   w_pkt;
  logic                      w_ok, w_full, w_empty, w_accept, w_push, w_pop;

  logic [PACKET_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic                      r_live;

  assign w_cx      = wb_in[WB_WIDTH-1 -: CELL_ID_WIDTH];
  assign w_cy      = wb_in[WB_WIDTH-1-CELL_ID_WIDTH -: CELL_ID_WIDTH];
  assign w_cz      = wb_in[WB_WIDTH-1-2*CELL_ID_WIDTH -: CELL_ID_WIDTH];
  assign w_payload = wb_in[PAYLOAD_WIDTH-1:0];

  assign w_ok   = axis_ok(int'(w_cx), XSIZE) & axis_ok(int'(w_cy), YSIZE) &
                  axis_ok(int'(w_cz), ZSIZE);
  assign w_dest = NODE_ID_WIDTH'(coord_to_node(int'(w_cx), int'(w_cy), int'(w_cz),
                                               XSIZE, YSIZE, ZSIZE));
  assign w_pkt  = {w_dest, w_payload};

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // r_live keeps wb_ready low until the first edge after reset release
  assign wb_ready  = r_live & ~w_full;
  assign pkt_valid = ~w_empty;
  assign pkt_out   = w_empty ? '0 : r_mem[r_rd_ptr];

  assign w_accept = wb_valid & wb_ready;
  assign w_push   = w_accept & w_ok;
  assign w_pop    = pkt_valid & pkt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_pkt;
  end

`ifdef DEST_MAP_ERR_CNT_EN
  err_cnt_t r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_accept && !w_ok && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + err_cnt_t'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`endif
endmodule

// File: rtl/dest_id_map_fifo.sv
// Writeback-to-ring mapper: NUM_CELLS independent map+FIFO channels.
// Define DEST_MAP_ERR_CNT_EN to add the per-channel err_cnt output.
module dest_id_map_fifo
  import md_ring_pkg::*;
#(
  parameter int NUM_CELLS         = 64,
  parameter int DATA_WIDTH        = 32,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int XSIZE             = 4,
  parameter int YSIZE             = 4,
  parameter int ZSIZE             = 4,
  parameter int FIFO_DEPTH        = 4,
  parameter int NODE_ID_WIDTH     = $clog2(NUM_CELLS),
  parameter int WB_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH + 3*DATA_WIDTH,
  parameter int PACKET_WIDTH      = NODE_ID_WIDTH + PARTICLE_ID_WIDTH + 3*DATA_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_CELLS-1:0]                   wb_valid,
  input  logic [NUM_CELLS-1:0][WB_WIDTH-1:0]     wb_in,
  output logic [NUM_CELLS-1:0]                   wb_ready,
  output logic [NUM_CELLS-1:0]                   pkt_valid,
  output logic [NUM_CELLS-1:0][PACKET_WIDTH-1:0] pkt_out,
  input  logic [NUM_CELLS-1:0]                   pkt_ready
`ifdef DEST_MAP_ERR_CNT_EN
  ,
  output err_cnt_t [NUM_CELLS-1:0]               err_cnt
`endif
);
  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_chan
    dest_id_map_chan #(
      .NUM_CELLS        (NUM_CELLS),
      .DATA_WIDTH       (DATA_WIDTH),
      .CELL_ID_WIDTH    (CELL_ID_WIDTH),
      .PARTICLE_ID_WIDTH(PARTICLE_ID_WIDTH),
      .XSIZE            (XSIZE),
      .YSIZE            (YSIZE),
      .ZSIZE            (ZSIZE),
      .FIFO_DEPTH       (FIFO_DEPTH),
      .NODE_ID_WIDTH    (NODE_ID_WIDTH),
      .WB_WIDTH         (WB_WIDTH),
      .PACKET_WIDTH     (PACKET_WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_valid (wb_valid[g]),
      .wb_in    (wb_in[g]),
      .wb_ready (wb_ready[g]),
      .pkt_valid(pkt_valid[g]),
      .pkt_out  (pkt_out[g]),
      .pkt_ready(pkt_ready[g])
`ifdef DEST_MAP_ERR_CNT_EN
      ,
      .err_cnt  (err_cnt[g])
`endif
    );
  end
endmodule

// File: tb/tb_dest_id_map_fifo.sv
// Self-checking bench for dest_id_map_fifo (4x4x4 grid, depth-4 FIFOs).
// err_cnt checks are included when DEST_MAP_ERR_CNT_EN is defined.
module tb_dest_id_map_fifo;
  localparam int NC    = 64;
  localparam int WBW   = 112;
  localparam int PKW   = 109;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NC-1:0]          wb_valid, wb_ready, pkt_valid, pkt_ready;
  logic [NC-1:0][WBW-1:0] wb_in;
  logic [NC-1:0][PKW-1:0] pkt_out;
`ifdef DEST_MAP_ERR_CNT_EN
  logic [NC-1:0][15:0]    err_cnt;
  int                     mdl_err [NC];
`endif

  int checks = 0;
  int errors = 0;
  logic [PKW-1:0] mq [NC][$];

  typedef struct {
    int   ch;
    int   x, y, z;
    logic ok;
    int   dest;
  } vec_t;
  vec_t vecs [11];

  always #5 clk = ~clk;

  dest_id_map_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_valid (wb_valid),
    .wb_in    (wb_in),
    .wb_ready (wb_ready),
    .pkt_valid(pkt_valid),
    .pkt_out  (pkt_out),
    .pkt_ready(pkt_ready)
`ifdef DEST_MAP_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // periodic wrap expressed as modulo arithmetic on 0..N+1
  function automatic int ref_dest(input int x, input int y, input int z);
    return ((z + 3) % 4) * 16 + ((y + 3) % 4) * 4 + (x + 3) % 4;
  endfunction

  function automatic logic [WBW-1:0] mk_wb(input int x, input int y, input int z,
      input logic [6:0] pid, input logic [31:0] fx, input logic [31:0] fy, input logic [31:0] fz);
    return {3'(x), 3'(y), 3'(z), pid, fx, fy, fz};
  endfunction

  function automatic logic [PKW-1:0] mk_pkt(input int dest, input logic [6:0] pid,
      input logic [31:0] fx, input logic [31:0] fy, input logic [31:0] fz);
    return {6'(dest), pid, fx, fy, fz};
  endfunction

  function automatic logic [PKW-1:0] bp_pkt(input int k);
    return mk_pkt(k % 4, 7'(k), 32'hA000_0000 + k, 32'hB000_0000 + k, 32'hC000_0000 + k);
  endfunction

  task automatic check_all(input string tag);
    for (int ch = 0; ch < NC; ch++) begin
      chk($sformatf("%s_wb_ready[%0d]", tag, ch), wb_ready[ch], mq[ch].size() < DEPTH);
      chk($sformatf("%s_pkt_valid[%0d]", tag, ch), pkt_valid[ch], mq[ch].size() > 0);
      if (mq[ch].size() > 0)
        chk($sformatf("%s_pkt_out[%0d]", tag, ch), pkt_out[ch], mq[ch][0]);
`ifdef DEST_MAP_ERR_CNT_EN
      chk($sformatf("%s_err_cnt[%0d]", tag, ch), err_cnt[ch], mdl_err[ch]);
`endif
    end
  endtask

  // called at posedge+1: check, drive next inputs, advance model to the next edge
  task automatic random_cycle(input string tag, input int pv_pct, input int pr_pct);
    check_all(tag);
    for (int ch = 0; ch < NC; ch++) begin
      logic wv, pr, ok, full;
      int x, y, z;
      logic [6:0] pid;
      logic [31:0] fx, fy, fz;
      wv  = ($urandom_range(0, 99) < pv_pct);
      pr  = ($urandom_range(0, 99) < pr_pct);
      x   = $urandom_range(0, 7);
      y   = $urandom_range(0, 7);
      z   = $urandom_range(0, 7);
      pid = 7'($urandom);
      fx  = $urandom;
      fy  = $urandom;
      fz  = $urandom;
      wb_valid[ch]  = wv;
      pkt_ready[ch] = pr;
      wb_in[ch]     = mk_wb(x, y, z, pid, fx, fy, fz);
      ok   = (x <= 5) && (y <= 5) && (z <= 5);
      full = (mq[ch].size() >= DEPTH);
      if (pr && mq[ch].size() > 0) void'(mq[ch].pop_front());
      if (wv && !full) begin
        if (ok) mq[ch].push_back(mk_pkt(ref_dest(x, y, z), pid, fx, fy, fz));
`ifdef DEST_MAP_ERR_CNT_EN
        else if (mdl_err[ch] < 65535) mdl_err[ch]++;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    wb_valid  = '0;
    pkt_ready = '0;
    wb_in     = '0;
`ifdef DEST_MAP_ERR_CNT_EN
    for (int ch = 0; ch < NC; ch++) mdl_err[ch] = 0;
`endif
    vecs[0]  = '{5, 2, 3, 1, 1'b1, 9};
    vecs[1]  = '{0, 0, 5, 1, 1'b1, 3};
    vecs[2]  = '{1, 5, 5, 5, 1'b1, 0};
    vecs[3]  = '{2, 6, 1, 1, 1'b0, 0};
    vecs[4]  = '{3, 4, 4, 4, 1'b1, 63};
    vecs[5]  = '{7, 1, 1, 0, 1'b1, 48};
    vecs[6]  = '{8, 1, 7, 1, 1'b0, 0};
    vecs[7]  = '{9, 0, 0, 0, 1'b1, 63};
    vecs[8]  = '{10, 3, 1, 2, 1'b1, 18};
    vecs[9]  = '{11, 1, 1, 7, 1'b0, 0};
    vecs[10] = '{12, 5, 2, 4, 1'b1, 52};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_ready", wb_ready, '0);
    chk("rst_pkt_valid", pkt_valid, '0);
    for (int ch = 0; ch < NC; ch++) chk($sformatf("rst_pkt_out[%0d]", ch), pkt_out[ch], '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("wb_ready_before_first_edge", wb_ready, '0);
    @(posedge clk);
    #1;
    chk("wb_ready_after_first_edge", wb_ready, {NC{1'b1}});

    for (int i = 0; i < 11; i++) begin
      int ch;
      logic [6:0] pid;
      logic [31:0] fx, fy, fz;
      ch  = vecs[i].ch;
      pid = 7'(i + 1);
      fx  = 32'h1000_0000 + i;
      fy  = 32'h2000_0000 + i;
      fz  = 32'h3000_0000 + i;
      wb_in[ch]     = mk_wb(vecs[i].x, vecs[i].y, vecs[i].z, pid, fx, fy, fz);
      wb_valid[ch]  = 1'b1;
      pkt_ready[ch] = 1'b1;
      chk($sformatf("vec%0d_wb_ready", i), wb_ready[ch], 1'b1);
      chk($sformatf("vec%0d_idle_valid", i), pkt_valid[ch], 1'b0);
      @(posedge clk);
      #1;
      wb_valid[ch] = 1'b0;
      chk($sformatf("vec%0d_pkt_valid", i), pkt_valid[ch], vecs[i].ok);
      if (vecs[i].ok)
        chk($sformatf("vec%0d_pkt_out", i), pkt_out[ch], mk_pkt(vecs[i].dest, pid, fx, fy, fz));
`ifdef DEST_MAP_ERR_CNT_EN
      if (!vecs[i].ok) mdl_err[ch]++;
      chk($sformatf("vec%0d_err_cnt", i), err_cnt[ch], mdl_err[ch]);
`endif
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_drained", i), pkt_valid[ch], 1'b0);
      pkt_ready[ch] = 1'b0;
    end

    pkt_ready[20] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_wb_ready_%0d", k), wb_ready[20], (k < DEPTH) ? 1'b1 : 1'b0);
      wb_valid[20] = 1'b1;
      wb_in[20]    = mk_wb(1 + k % 4, 1, 1, 7'(k), 32'hA000_0000 + k, 32'hB000_0000 + k,
                           32'hC000_0000 + k);
      @(posedge clk);
      #1;
    end
    wb_valid[20] = 1'b0;
    chk("bp_full_wb_ready", wb_ready[20], 1'b0);
    chk("bp_full_pkt_valid", pkt_valid[20], 1'b1);
    chk("bp_head", pkt_out[20], bp_pkt(0));
    @(posedge clk);
    #1;
    chk("bp_head_stable", pkt_out[20], bp_pkt(0));
    pkt_ready[20] = 1'b1;
    #1;
    chk("bp_full_with_pop_ready", wb_ready[20], 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) chk("bp_ready_after_first_pop", wb_ready[20], 1'b1);
      if (k < 3) begin
        chk($sformatf("bp_valid_%0d", k + 1), pkt_valid[20], 1'b1);
        chk($sformatf("bp_order_%0d", k + 1), pkt_out[20], bp_pkt(k + 1));
      end else begin
        chk("bp_empty", pkt_valid[20], 1'b0);
      end
    end
    pkt_ready[20] = 1'b0;

    repeat (300) random_cycle("rnd", 50, 50);
    repeat (15) random_cycle("fill", 70, 15);
    check_all("pre_rst");

    wb_valid  = '0;
    pkt_ready = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pkt_valid", pkt_valid, '0);
    chk("midrst_wb_ready", wb_ready, '0);
    for (int ch = 0; ch < NC; ch++) begin
      chk($sformatf("midrst_pkt_out[%0d]", ch), pkt_out[ch], '0);
`ifdef DEST_MAP_ERR_CNT_EN
      chk($sformatf("midrst_err_cnt[%0d]", ch), err_cnt[ch], '0);
      mdl_err[ch] = 0;
`endif
      mq[ch].delete();
    end
    @(posedge clk);
    #1;
    chk("rst_hold_wb_ready", wb_ready, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_wb_ready", wb_ready, {NC{1'b1}});
    chk("post_rst_pkt_valid", pkt_valid, '0);

    repeat (100) random_cycle("post", 50, 50);
    check_all("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dest_id_map_fifo.md
DEST_ID_MAP_FIFO -- requirements
Module: dest_id_map_fifo

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 64, meaning number of ring nodes/channels, equal to XSIZE*YSIZE*ZSIZE.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning width of one force component.
REQ-003 SHALL have parameter CELL_ID_WIDTH, default 3, meaning width of one cell coordinate; must hold values 0..max(XSIZE,YSIZE,ZSIZE)+1.
REQ-004 SHALL have parameter PARTICLE_ID_WIDTH, default 7, meaning particle index width.
REQ-005 SHALL have parameters XSIZE/YSIZE/ZSIZE, default 4/4/4, meaning cell grid dimensions.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning per-channel packet buffer depth (power of two, at least 2).
REQ-007 SHALL have derived parameters NODE_ID_WIDTH=$clog2(NUM_CELLS), WB_WIDTH=3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH+3*DATA_WIDTH, PACKET_WIDTH=NODE_ID_WIDTH+PARTICLE_ID_WIDTH+3*DATA_WIDTH.
REQ-008 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-009 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-010 SHALL have wb_valid  input  NUM_CELLS  per-channel writeback request valid.
REQ-011 SHALL have wb_in  input  NUM_CELLS x WB_WIDTH  per-channel writeback, MSB first {cell_x, cell_y, cell_z, particle_id, fx, fy, fz}.
REQ-012 SHALL have wb_ready  output  NUM_CELLS  per-channel accept.
REQ-013 SHALL have pkt_valid  output  NUM_CELLS  per-channel packet valid.
REQ-014 SHALL have pkt_out  output  NUM_CELLS x PACKET_WIDTH  packet, MSB first {dest_node, particle_id, fx, fy, fz}.
REQ-015 SHALL have pkt_ready  input  NUM_CELLS  ring injection ready.

Function
REQ-016 Channels SHALL operate independently; transfer occurs when valid and ready are both high in a cycle.
REQ-017 Coordinates SHALL be 1-based; value 0 wraps to N and N+1 wraps to 1 (periodic boundary), per axis, with N being that axis's size.
REQ-018 dest_node SHALL equal (z-1)*XSIZE*YSIZE + (y-1)*XSIZE + (x-1) after wrap, computed at NODE_ID_WIDTH bits.
REQ-019 Coordinate above N+1 on any axis SHALL mark the request invalid: accepted (handshake completes), not buffered, no packet produced.
REQ-020 Valid mapped requests SHALL be written to the channel FIFO; pkt_valid SHALL rise the cycle after acceptance into an empty FIFO (latency 1, no combinational bypass).
REQ-021 wb_ready SHALL equal FIFO not full; when full, wb_ready is low even if pkt_ready is high in the same cycle.
REQ-022 pkt_valid SHALL equal FIFO not empty; pkt_out SHALL present the head entry and stay stable while pkt_valid and not pkt_ready.
REQ-023 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged; ordering SHALL be strict FIFO per channel.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 While rst_n is low: pointers and occupancy cleared; pkt_valid=0; wb_ready=0; pkt_out=0; error counters (if built) =0.
REQ-026 wb_ready SHALL go high on the first rising clk edge after rst_n deasserts; reset mid-operation SHALL discard all buffered packets.

Configuration
REQ-027 With macro DEST_MAP_ERR_CNT_EN defined, SHALL add output err_cnt  NUM_CELLS x 16  per-channel saturating (stays at 16'hFFFF) count of invalid requests dropped per REQ-019.
REQ-028 Without DEST_MAP_ERR_CNT_EN, err_cnt port and counters SHALL not exist; drop behaviour is unchanged.

Structure
REQ-029 Packet field widths, the wb/packet structure typedefs, and the coordinate-to-node function SHALL reside in shared package md_ring_pkg.
REQ-030 Per-channel logic (map, validity check, FIFO, counter) SHALL be sub-module dest_id_map_chan, instantiated NUM_CELLS times by a generate loop.

Verification (XSIZE=YSIZE=ZSIZE=4, FIFO_DEPTH=4)
REQ-031 Channel 5 accepts {x=2,y=3,z=1}, pkt_ready=1 -> next cycle pkt_valid=1, dest_node=9, payload unchanged.
REQ-032 Wrap: {x=0,y=5,z=1} -> dest_node=3; {x=5,y=5,z=5} -> dest_node=0.
REQ-033 Invalid {x=6,y=1,z=1} -> wb_ready=1 and accepted, no pkt_valid, err_cnt increments by 1 (with macro).
REQ-034 pkt_ready=0, push 5 valid requests -> 4 accepted, wb_ready low from cycle 4 on; release pkt_ready -> 4 packets in order, wb_ready high the cycle after first pop.
REQ-035 Random traffic on all 64 channels with random pkt_ready; assert rst_n low with FIFOs half full -> pkt_valid=0 immediately, all outputs at reset values, ordering scoreboard clean before reset.
